// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Contents:
//   state_t - FSM state encoding (IDLE / SHIFT / DONE)
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor: computes a - b - bin for a single bit.
// Ports:
//   a, b, bin - minuend bit, subtrahend bit, borrow-in
//   d, bout   - difference bit, borrow-out
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when they tie and a borrow is pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: accepts a WIDTH-bit operand pair plus borrow-in,
// processes one bit per cycle LSB first, then holds the result until consumed.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   in_valid / in_ready   - operand handshake (ready only in IDLE)
//   a_i, b_i, bin_i       - minuend, subtrahend, borrow-in
//   out_valid / out_ready - result handshake (valid only in DONE)
//   diff_o, bout_o        - (a - b - bin) mod 2^WIDTH and final borrow-out
//   busy_o                - high while shifting
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             busy_o
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d_bit, br_next;
    logic             accept;

    assign accept = in_valid && (state == IDLE);

    fs_cell u_fs_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)      state_next = SHIFT;
            SHIFT:   if (cnt == LAST)   state_next = DONE;
            DONE:    if (out_ready)     state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr <= a_i;
            b_sr <= b_i;
            br   <= bin_i;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            // After WIDTH shifts the first bit lands in bit 0.
            res_sr <= {d_bit, res_sr[WIDTH-1:1]};
            br     <= br_next;
            cnt    <= cnt + CW'(1);
        end
    end

    // Result and borrow come straight from flops; they only move in SHIFT,
    // so they are stable for the whole DONE interval.
    assign diff_o    = res_sr;
    assign bout_o    = br;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy_o    = (state == SHIFT);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] a_i, b_i;
    logic             bin_i;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] diff_o;
    logic             bout_o, busy_o;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .bin_i     (bin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff_o    (diff_o),
        .bout_o    (bout_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on a 9-bit value; bit 8 is the borrow.
    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic bin);
        ref_sub = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand set for one edge; returns after the accept edge.
    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        a_i      = a;
        b_i      = b;
        bin_i    = bin;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Edges counted with the accept edge as edge 1; -1 on timeout.
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!out_valid && edges < 60) begin
            step();
            edges++;
        end
        if (!out_valid) edges = -1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i = '0; b_i = '0; bin_i = 1'b0;
        step();
        step();
        checks++;
        if ({in_ready, out_valid, busy_o, bout_o} !== 4'b1000 || diff_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b busy=%b bout=%b diff=%h, want 1 0 0 0 00",
                     in_ready, out_valid, busy_o, bout_o, diff_o);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] av [4] = '{8'h05, 8'h03, 8'h00, 8'hFF};
        logic [WIDTH-1:0] bv [4] = '{8'h03, 8'h05, 8'h00, 8'hFF};
        logic             cv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [WIDTH:0]   ev [4] = '{9'h002, 9'h1FE, 9'h1FF, 9'h000};
        int edges;
        for (int i = 0; i < 4; i++) begin
            accept(av[i], bv[i], cv[i]);
            checks++;
            if (busy_o !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL directed_busy[%0d]: busy=%b rdy=%b, want 1 0", i, busy_o, in_ready);
            end
            wait_valid(edges);
            checks++;
            if (edges !== WIDTH + 1) begin
                errors++;
                $display("FAIL directed_latency[%0d]: edges=%0d, want %0d", i, edges, WIDTH + 1);
            end
            checks++;
            if ({bout_o, diff_o} !== ev[i] || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL directed_result[%0d]: bout=%b diff=%h busy=%b, want bout=%b diff=%h",
                         i, bout_o, diff_o, busy_o, ev[i][WIDTH], ev[i][WIDTH-1:0]);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_consume[%0d]: vld=%b rdy=%b, want 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH:0] exp;
        int edges;
        exp = ref_sub(8'hA7, 8'h3C, 1'b1);
        accept(8'hA7, 8'h3C, 1'b1);
        wait_valid(edges);
        checks++;
        if (edges !== WIDTH + 1) begin
            errors++;
            $display("FAIL bp_latency: edges=%0d, want %0d", edges, WIDTH + 1);
        end
        for (int i = 0; i < 5; i++) begin
            a_i = 8'($urandom); b_i = 8'($urandom); bin_i = 1'($urandom);
            in_valid = 1'b1;
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy_o !== 1'b0 || {bout_o, diff_o} !== exp) begin
                errors++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b busy=%b bout=%b diff=%h, want 1 0 0 %b %h",
                         i, out_valid, in_ready, busy_o, bout_o, diff_o, exp[WIDTH], exp[WIDTH-1:0]);
            end
        end
        // in_valid still high on the consume edge: must not start a new op.
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b busy=%b, want 0 1 0", out_valid, in_ready, busy_o);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [WIDTH:0] exp;
        int edges;
        bit saw_valid;
        accept(8'hC3, 8'h21, 1'b0);
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, busy_o, bout_o} !== 4'b1000 || diff_o !== 8'h00) begin
            errors++;
            $display("FAIL midreset_async: rdy=%b vld=%b busy=%b bout=%b diff=%h, want 1 0 0 0 00",
                     in_ready, out_valid, busy_o, bout_o, diff_o);
        end
        step();
        step();
        reset = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_valid: out_valid pulsed after aborted op");
        end
        exp = ref_sub(8'h10, 8'h01, 1'b0);
        accept(8'h10, 8'h01, 1'b0);
        wait_valid(edges);
        checks++;
        if (edges !== WIDTH + 1 || {bout_o, diff_o} !== exp || exp !== 9'h00F) begin
            errors++;
            $display("FAIL midreset_resume: edges=%0d bout=%b diff=%h, want edges=%0d bout=0 diff=0f",
                     edges, bout_o, diff_o, WIDTH + 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        logic             bin;
        logic [WIDTH:0]   exp;
        int edges;
        int bad = 0;
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            exp = ref_sub(a, b, bin);
            accept(a, b, bin);
            // Junk on the input side and out_ready while shifting must be ignored.
            edges = 1;
            while (!out_valid && edges < 60) begin
                in_valid  = 1'($urandom);
                a_i       = 8'($urandom);
                out_ready = 1'($urandom);
                step();
                edges++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            checks++;
            if (!out_valid || edges !== WIDTH + 1 || {bout_o, diff_o} !== exp) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: a=%h b=%h bin=%b edges=%0d bout=%b diff=%h, want edges=%0d bout=%b diff=%h",
                             n, a, b, bin, edges, bout_o, diff_o, WIDTH + 1, exp[WIDTH], exp[WIDTH-1:0]);
                if (!out_valid) return;
            end
            // Randomly stall the consumer for a few cycles.
            for (int s = $urandom_range(0, 2); s > 0; s--) step();
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 Port in_valid  input  1  SHALL indicate that a_i, b_i and bin_i are valid.
REQ-005 Port in_ready  output  1  SHALL indicate that the block can accept an operand set.
REQ-006 Port a_i  input  WIDTH  is the minuend.
REQ-007 Port b_i  input  WIDTH  is the subtrahend.
REQ-008 Port bin_i  input  1  is the borrow-in.
REQ-009 Port out_valid  output  1  SHALL indicate that diff_o and bout_o hold a finished result.
REQ-010 Port out_ready  input  1  SHALL indicate that the consumer accepts the result.
REQ-011 Port diff_o  output  WIDTH  SHALL carry the difference, (a - b - bin) mod 2^WIDTH.
REQ-012 Port bout_o  output  1  SHALL carry the final borrow-out.
REQ-013 Port busy_o  output  1  SHALL be high while the state is SHIFT.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be high only in IDLE; an operand set is accepted on an edge where in_valid && in_ready.
REQ-016 On accept, the block SHALL:
- latch a_i and b_i into shift registers;
- load the borrow register with bin_i;
- clear the bit counter;
- go to SHIFT.
REQ-017 In SHIFT, each cycle SHALL process one bit, LSB first:
- d = a0 ^ b0 ^ br;
- br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
- d is shifted into the MSB of the result register;
- both operand registers shift right by one.
REQ-018 The counter SHALL use a width of clog2(WIDTH) bits; the last bit is processed when count == WIDTH-1, then the FSM moves to DONE.
REQ-019 Latency SHALL be exactly WIDTH+1 edges from the accept edge to the first cycle with out_valid high.
REQ-020 In DONE, out_valid SHALL be high, and diff_o and bout_o SHALL stay stable until the edge where out_ready is high, which returns the FSM to IDLE.
REQ-021 out_ready held low SHALL hold DONE indefinitely, with no loss or change of the result.
REQ-022 in_valid SHALL be ignored outside IDLE; a new operand set is never accepted in the same cycle a result is consumed.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 diff_o and bout_o SHALL be registered outputs; their value outside DONE is don't-care to the consumer but SHALL NOT be X after reset.

Reset
REQ-025 reset high SHALL asynchronously force:
- state to IDLE;
- all shift, result, borrow and counter registers to 0;
- in_ready to 1, out_valid to 0, busy_o to 0, diff_o to 0, bout_o to 0.
REQ-026 reset asserted mid-SHIFT or in DONE SHALL discard the operation with no out_valid pulse; normal operation SHALL resume on the first edge after reset deasserts.

Structure
REQ-027 The state enum (IDLE/SHIFT/DONE) SHALL live in shared package serial_sub_pkg.
REQ-028 The one-bit subtract equations SHALL be a combinational sub-module fs_cell (inputs a, b, bin; outputs d, bout), instantiated once.
REQ-029 The counter width SHALL be derived from WIDTH, with no hard-coded widths.

Verification (WIDTH=8)
REQ-030 a=0x05, b=0x03, bin=0 -> diff 0x02, bout 0, out_valid exactly 9 edges after accept.
REQ-031 a=0x03, b=0x05, bin=0 -> diff 0xFE, bout 1.
REQ-032 a=0x00, b=0x00, bin=1 -> diff 0xFF, bout 1; a=0xFF, b=0xFF, bin=0 -> diff 0x00, bout 0.
REQ-033 Backpressure: hold out_ready low for 5 cycles after out_valid -> result stable, in_ready stays 0, in_valid pulses are ignored; then out_ready high -> IDLE on the next edge.
REQ-034 Reset asserted 3 cycles into SHIFT -> outputs reach their reset values immediately, no out_valid; a following 0x10-0x01 -> diff 0x0F, bout 0.
REQ-035 Random sweep of 1000 vectors checked against (a - b - bin) with a 9-bit reference model.
